// File: rtl/message_tx.sv
// Serial frame transmitter: start bit, DATA_WIDTH bits LSB first, then 1 or 2 stop bits.
// Advances one bit per rising edge of the bit_clk level; a one-entry hold register allows back-to-back frames.
module message_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_clk,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  tx,
  output logic                  busy
);

  localparam int            CW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state;
  logic                  bit_clk_q;
  logic                  tick;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] shift;
  logic [CW-1:0]         bit_cnt;
  logic                  stop_cnt;

  assign tick       = bit_clk & ~bit_clk_q;
  assign data_ready = ~hold_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      bit_clk_q  <= 1'b1;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
    end else begin
      bit_clk_q <= bit_clk;

      // Accept only into an empty holder; the FSM only drains a full one, so these never collide.
      if (data_valid && !hold_valid) begin
        hold_valid <= 1'b1;
        hold_data  <= data_in;
      end

      if (tick) begin
        case (state)
          IDLE: begin
            if (hold_valid) begin
              shift      <= hold_data;
              hold_valid <= 1'b0;
              tx         <= 1'b0;
              busy       <= 1'b1;
              state      <= START;
            end
          end
          START: begin
            tx      <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
          DATA: begin
            if (bit_cnt == LAST_BIT) begin
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
            end else begin
              tx      <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          STOP: begin
            if (stop_cnt != LAST_STOP) begin
              stop_cnt <= stop_cnt + 1'b1;
            end else if (hold_valid) begin
              shift      <= hold_data;
              hold_valid <= 1'b0;
              tx         <= 1'b0;
              state      <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: begin
            tx    <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
